p4_ingress_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single AXI4-Stream ingress of the P4 router's Vitis Networking P4 core among NUM_PORTS source streams. It tags each packet with its ingress port number on the core's user metadata bus. It also keeps per-port packet counters for the control plane. It sits directly in front of the VNP4 instance inside the P4 router top level, on the same clock.

---
 rtl/p4_ingress_arbiter.sv | 122 ++++++++++++
 tb/tb_p4_ingress_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_ingress_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI4-Stream sources onto the
// single VNP4 ingress; tags each packet with its port index and counts packets per port.

module p4_ingress_arbiter_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] cnt
);
  logic [31:0] count_q;

  // Free-running wrap at 2^32; the control plane handles rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count_q <= '0;
    else if (inc) count_q <= count_q + 32'd1;
  end

  assign cnt = count_q;
endmodule

module p4_ingress_arbiter #(
  parameter  int NUM_PORTS     = 4,
  parameter  int DATA_BYTES    = 8,
  parameter  int METADATA_BITS = 19,
  localparam int PORT_BITS     = $clog2(NUM_PORTS)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    port_enable,
  input  logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0]  data_in_tdata,
  input  logic [NUM_PORTS-1:0][DATA_BYTES-1:0]    data_in_tkeep,
  input  logic [NUM_PORTS-1:0]                    data_in_tlast,
  input  logic [NUM_PORTS-1:0]                    data_in_tvalid,
  output logic [NUM_PORTS-1:0]                    data_in_tready,
  output logic [DATA_BYTES*8-1:0]                 data_out_tdata,
  output logic [DATA_BYTES-1:0]                   data_out_tkeep,
  output logic                                    data_out_tlast,
  output logic                                    data_out_tvalid,
  input  logic                                    data_out_tready,
  output logic [METADATA_BITS-1:0]                user_metadata,
  output logic                                    user_metadata_valid,
  output logic [NUM_PORTS-1:0][31:0]              pkt_count,
  output logic                                    busy
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t               state_q, state_d;
  logic [PORT_BITS-1:0] grant_q, last_q;
  logic [NUM_PORTS-1:0] req;
  logic [PORT_BITS-1:0] pick, idx;
  logic                 found;
  logic                 pass, pkt_done;

  assign req  = data_in_tvalid & port_enable;
  assign pass = (state_q == PASS);

  // Search upward from the port after the last winner, wrapping once.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = PORT_BITS'((int'(last_q) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    data_in_tready      = '0;
    data_out_tvalid     = 1'b0;
    data_out_tdata      = '0;
    data_out_tkeep      = '0;
    data_out_tlast      = 1'b0;
    user_metadata       = '0;
    user_metadata_valid = 1'b0;
    pkt_done            = 1'b0;
    case (state_q)
      IDLE: if (found) state_d = PASS;
      PASS: begin
        data_out_tvalid         = data_in_tvalid[grant_q];
        data_out_tdata          = data_in_tdata[grant_q];
        data_out_tkeep          = data_in_tkeep[grant_q];
        data_out_tlast          = data_in_tlast[grant_q];
        data_in_tready[grant_q] = data_out_tready;
        user_metadata           = METADATA_BITS'(grant_q);
        user_metadata_valid     = data_out_tvalid & data_out_tlast;
        pkt_done                = data_out_tvalid & data_out_tready & data_out_tlast;
        if (pkt_done) state_d = IDLE;
      end
    endcase
  end

  // last_q resets to the top port so port 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PORT_BITS'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) grant_q <= pick;
      if (pkt_done)                 last_q  <= grant_q;
    end
  end

  assign busy = pass;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    p4_ingress_arbiter_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pkt_done && (grant_q == PORT_BITS'(i))),
      .cnt   (pkt_count[i])
    );
  end

endmodule

// File: tb/tb_p4_ingress_arbiter.sv
// Bench for p4_ingress_arbiter: directed vector table, directed corner sequences, and
// randomized traffic against a packet-level reference model.
module tb_p4_ingress_arbiter;
  localparam int N = 4, DB = 8, MB = 19;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]              port_enable;
  logic [N-1:0][DB*8-1:0]    in_tdata;
  logic [N-1:0][DB-1:0]      in_tkeep;
  logic [N-1:0]              in_tlast, in_tvalid, in_tready;
  logic [DB*8-1:0]           out_tdata;
  logic [DB-1:0]             out_tkeep;
  logic                      out_tlast, out_tvalid, out_tready;
  logic [MB-1:0]             user_metadata;
  logic                      user_metadata_valid;
  logic [N-1:0][31:0]        pkt_count;
  logic                      busy;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  p4_ingress_arbiter #(.NUM_PORTS(N), .DATA_BYTES(DB), .METADATA_BITS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .port_enable(port_enable),
    .data_in_tdata(in_tdata), .data_in_tkeep(in_tkeep), .data_in_tlast(in_tlast),
    .data_in_tvalid(in_tvalid), .data_in_tready(in_tready),
    .data_out_tdata(out_tdata), .data_out_tkeep(out_tkeep), .data_out_tlast(out_tlast),
    .data_out_tvalid(out_tvalid), .data_out_tready(out_tready),
    .user_metadata(user_metadata), .user_metadata_valid(user_metadata_valid),
    .pkt_count(pkt_count), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_data(input int p, input int seq, input int b);
    return {8'(p), 24'(seq), 32'h5A00_0000 | 32'(b)};
  endfunction

  // Source generators and reference model state
  bit          src_on[N];
  int          fix_len[N], src_len[N], src_beat[N], src_seq[N];
  bit          vld_hold[N];
  int          vprob = 100, rprob = 100;
  int          owner, last_g;
  logic [31:0] cnt[N];
  int          dlog[$];
  bit          prev_busy;

  function automatic int new_len(input int p);
    return (fix_len[p] > 0) ? fix_len[p] : int'($urandom_range(1, 5));
  endfunction

  function automatic longint tot_cnt();
    longint s = 0;
    for (int p = 0; p < N; p++) s += longint'(cnt[p]);
    return s;
  endfunction

  task automatic model_reset();
    owner  = -1;
    last_g = N - 1;
    for (int p = 0; p < N; p++) begin
      cnt[p]      = '0;
      src_beat[p] = 0;
      src_seq[p]  = src_seq[p] + 1;
      src_len[p]  = new_len(p);
      vld_hold[p] = 1'b0;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      in_tvalid[p] = src_on[p] && (vld_hold[p] || (int'($urandom_range(99)) < vprob));
      in_tdata[p]  = beat_data(p, src_seq[p], src_beat[p]);
      in_tlast[p]  = (src_beat[p] == src_len[p] - 1);
      in_tkeep[p]  = in_tlast[p] ? 8'h0F : 8'hFF;
    end
    out_tready = (int'($urandom_range(99)) < rprob);
  endtask

  // Called between edges: check outputs against the model, then advance it to the next edge.
  task automatic model_step();
    logic [N-1:0] e_rdy;
    int g, q;
    if (!rst_n) model_reset();
    if (busy && !prev_busy) dlog.push_back(int'(user_metadata));
    prev_busy = busy;
    if (owner < 0) begin
      chk("idle_tvalid", 64'(out_tvalid), 64'(0));
      chk("idle_busy",   64'(busy),       64'(0));
      chk("idle_tready", 64'(in_tready),  64'(0));
      chk("idle_umv",    64'(user_metadata_valid), 64'(0));
    end else begin
      g = owner;
      chk("tvalid", 64'(out_tvalid), 64'(in_tvalid[g]));
      if (in_tvalid[g]) begin
        chk("tdata", out_tdata,        in_tdata[g]);
        chk("tkeep", 64'(out_tkeep),   64'(in_tkeep[g]));
        chk("tlast", 64'(out_tlast),   64'(in_tlast[g]));
        chk("umv",   64'(user_metadata_valid), 64'(in_tlast[g]));
      end
      chk("meta", 64'(user_metadata), 64'(g));
      chk("busy", 64'(busy), 64'(1));
      e_rdy = '0;
      e_rdy[g] = out_tready;
      chk("tready", 64'(in_tready), 64'(e_rdy));
    end
    for (int p = 0; p < N; p++) chk("pkt_count", 64'(pkt_count[p]), 64'(cnt[p]));
    if (!rst_n) return;
    for (int p = 0; p < N; p++) vld_hold[p] = in_tvalid[p];
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        q = (last_g + k) % N;
        if (in_tvalid[q] && port_enable[q]) begin
          owner = q;
          break;
        end
      end
    end else if (in_tvalid[g] && out_tready) begin
      vld_hold[g] = 1'b0;
      if (in_tlast[g]) begin
        cnt[g]      = cnt[g] + 32'd1;
        last_g      = g;
        owner       = -1;
        src_seq[g]  = src_seq[g] + 1;
        src_beat[g] = 0;
        src_len[g]  = new_len(g);
      end else begin
        src_beat[g] = src_beat[g] + 1;
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    dlog.delete();
  endtask

  task automatic all_src(input bit on, input int len);
    for (int p = 0; p < N; p++) begin
      src_on[p]  = on;
      fix_len[p] = len;
    end
  endtask

  typedef struct {
    int port; int beat; bit last; bit otr;
    bit e_tv; bit e_busy; bit e_mv; logic [3:0] e_rdy; int e_meta;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, n;
    bit all3;

    tbl[0]  = '{2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0};
    tbl[1]  = '{2, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 2};
    tbl[2]  = '{2, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 2};
    tbl[3]  = '{2, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
    tbl[4]  = '{-1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0};
    tbl[5]  = '{1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0};
    tbl[6]  = '{1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 1};
    tbl[7]  = '{1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1};
    tbl[8]  = '{1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 1};
    tbl[9]  = '{1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1};
    tbl[10] = '{1, 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 1};
    tbl[11] = '{1, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1};
    tbl[12] = '{1, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0010, 1};
    tbl[13] = '{-1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 0};

    all_src(1'b0, 0);
    model_reset();
    prev_busy   = 1'b0;
    port_enable = '1;
    in_tvalid   = '1;
    in_tlast    = '1;
    in_tkeep    = '1;
    in_tdata    = '1;
    out_tready  = 1'b1;

    // Reset state with every source requesting
    @(negedge clk);
    chk("rst_tvalid", 64'(out_tvalid), 64'(0));
    chk("rst_busy",   64'(busy),       64'(0));
    chk("rst_tready", 64'(in_tready),  64'(0));
    chk("rst_meta",   64'(user_metadata), 64'(0));
    chk("rst_umv",    64'(user_metadata_valid), 64'(0));
    for (int p = 0; p < N; p++) chk("rst_count", 64'(pkt_count[p]), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-port packet and backpressure, cycle by cycle
    for (int i = 0; i < 14; i++) begin
      in_tvalid  = '0;
      in_tlast   = '0;
      in_tkeep   = '1;
      in_tdata   = '0;
      out_tready = tbl[i].otr;
      if (tbl[i].port >= 0) begin
        in_tvalid[tbl[i].port] = 1'b1;
        in_tlast[tbl[i].port]  = tbl[i].last;
        in_tdata[tbl[i].port]  = beat_data(tbl[i].port, 7, tbl[i].beat);
      end
      @(negedge clk);
      chk("tbl_tvalid", 64'(out_tvalid), 64'(tbl[i].e_tv));
      chk("tbl_busy",   64'(busy),       64'(tbl[i].e_busy));
      chk("tbl_umv",    64'(user_metadata_valid), 64'(tbl[i].e_mv));
      chk("tbl_tready", 64'(in_tready),  64'(tbl[i].e_rdy));
      if (tbl[i].e_busy) chk("tbl_meta", 64'(user_metadata), 64'(tbl[i].e_meta));
      if (tbl[i].e_tv)   chk("tbl_tdata", out_tdata, beat_data(tbl[i].port, 7, tbl[i].beat));
      @(posedge clk);
      #1;
    end
    chk("tbl_count2", 64'(pkt_count[2]), 64'(1));
    chk("tbl_count1", 64'(pkt_count[1]), 64'(1));
    chk("tbl_count0", 64'(pkt_count[0]), 64'(0));

    // Round-robin fairness, all ports streaming 2-beat packets
    all_src(1'b0, 2);
    vprob = 100; rprob = 100; port_enable = '1;
    do_reset();
    all_src(1'b1, 2);
    for (int k = 0; k < 300 && tot_cnt() < 8; k++) cycle();
    chk("fair_timeout", 64'(tot_cnt() >= 8), 64'(1));
    for (int i = 0; i < 8; i++)
      chk("fair_order", 64'(dlog.size() > i ? dlog[i] : -1), 64'(i % 4));
    for (int p = 0; p < N; p++) chk("fair_count", 64'(pkt_count[p]), 64'(2));

    // Enable mask 1010, then drop port 1 mid-packet
    all_src(1'b0, 3);
    do_reset();
    port_enable = 4'b1010;
    all_src(1'b1, 3);
    for (int k = 0; k < 300 && dlog.size() < 4; k++) cycle();
    for (int i = 0; i < 4; i++)
      chk("mask_order", 64'(dlog.size() > i ? dlog[i] : -1), 64'((i % 2 == 0) ? 1 : 3));
    for (int k = 0; k < 100 && !(owner == 1 && src_beat[1] == 1); k++) cycle();
    chk("mask_mid_timeout", 64'(owner == 1 && src_beat[1] == 1), 64'(1));
    c1 = int'(cnt[1]);
    port_enable = 4'b1000;
    for (int k = 0; k < 100 && owner == 1; k++) cycle();
    chk("mask_complete", 64'(pkt_count[1]), 64'(c1 + 1));
    n = dlog.size();
    for (int k = 0; k < 60; k++) cycle();
    all3 = (dlog.size() > n);
    for (int i = n; i < dlog.size(); i++) if (dlog[i] != 3) all3 = 1'b0;
    chk("mask_only3", 64'(all3), 64'(1));

    // Counter wrap on port 0
    all_src(1'b0, 2);
    port_enable = '1;
    do_reset();
    force dut.g_lane[0].u_cnt.count_q = 32'hFFFF_FFFF;
    cnt[0] = 32'hFFFF_FFFF;
    #1;
    release dut.g_lane[0].u_cnt.count_q;
    chk("wrap_pre", 64'(pkt_count[0]), 64'hFFFF_FFFF);
    src_on[0] = 1'b1;
    for (int k = 0; k < 50 && cnt[0] != 0; k++) cycle();
    chk("wrap", 64'(pkt_count[0]), 64'(0));
    chk("wrap_other", 64'(pkt_count[1]), 64'(0));

    // Reset in the middle of a 5-beat packet
    all_src(1'b0, 5);
    do_reset();
    src_on[0] = 1'b1;
    for (int k = 0; k < 50 && !(owner == 0 && src_beat[0] == 2); k++) cycle();
    chk("rstmid_timeout", 64'(owner == 0 && src_beat[0] == 2), 64'(1));
    chk("rstmid_pre_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", 64'(out_tvalid), 64'(0));
    chk("rstmid_busy",   64'(busy),       64'(0));
    chk("rstmid_tready", 64'(in_tready),  64'(0));
    chk("rstmid_umv",    64'(user_metadata_valid), 64'(0));
    chk("rstmid_meta",   64'(user_metadata), 64'(0));
    cycle();
    rst_n = 1'b1;
    dlog.delete();
    all_src(1'b1, 2);
    for (int k = 0; k < 20 && dlog.size() == 0; k++) cycle();
    chk("rstmid_prio", 64'(dlog.size() > 0 ? dlog[0] : -1), 64'(0));

    // Randomized traffic against the model
    all_src(1'b0, 0);
    do_reset();
    all_src(1'b1, 0);
    vprob = 60; rprob = 70;
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) port_enable = 4'($urandom_range(1, 15));
      cycle();
    end
    chk("rand_progress", 64'(tot_cnt() > 20), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
